soc_bus_node: RTL and testbench



---
 rtl/soc_bus_node.sv | 240 ++++++++++++++++++++++++
 tb/tb_soc_bus_node.sv | 450 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/soc_bus_node.sv
// ---------------------------------------------------------------------------
// soc_bus_node
//   Request/grant interconnect node. It routes NB_MASTER initiators to
//   NB_SLAVE address regions. Each request is decoded against run-time
//   [start, end] bounds, and the lowest matching region wins. Each slave has
//   its own round-robin arbiter. Responses return to the master recorded as
//   the slave's owner. Unmapped requests are granted at once and answered
//   one cycle later by a local error responder.
//
//   Optional feature (macro BUS_NODE_TIMEOUT_EN): a per-slave response
//   watchdog. It errors out the owner after TIMEOUT_CYCLES and then silently
//   drops the late response.
//
// Ports
//   clk, rst_n                    clock, async active-low reset
//   start_addr_i / end_addr_i     per-slave inclusive region bounds
//   m_req_i, m_addr_i, m_we_i,    master request and payload
//   m_be_i, m_wdata_i
//   m_gnt_o                       master request accepted
//   m_rvalid_o, m_rdata_o,        master response (m_err_o qualified by
//   m_err_o                       m_rvalid_o)
//   s_req_o, s_addr_o, s_we_o,    forwarded request to each slave
//   s_be_o, s_wdata_o
//   s_gnt_i, s_rvalid_i,          slave accept / response
//   s_rdata_i
// ---------------------------------------------------------------------------
module soc_bus_node #(
   parameter int NB_MASTER      = 3,
   parameter int NB_SLAVE       = 3,
   parameter int ADDR_WIDTH     = 32,
   parameter int DATA_WIDTH     = 32,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic                                  clk,
   input  logic                                  rst_n,
   input  logic [NB_SLAVE-1:0][ADDR_WIDTH-1:0]   start_addr_i,
   input  logic [NB_SLAVE-1:0][ADDR_WIDTH-1:0]   end_addr_i,
   input  logic [NB_MASTER-1:0]                  m_req_i,
   input  logic [NB_MASTER-1:0][ADDR_WIDTH-1:0]  m_addr_i,
   input  logic [NB_MASTER-1:0]                  m_we_i,
   input  logic [NB_MASTER-1:0][DATA_WIDTH/8-1:0] m_be_i,
   input  logic [NB_MASTER-1:0][DATA_WIDTH-1:0]  m_wdata_i,
   output logic [NB_MASTER-1:0]                  m_gnt_o,
   output logic [NB_MASTER-1:0]                  m_rvalid_o,
   output logic [NB_MASTER-1:0][DATA_WIDTH-1:0]  m_rdata_o,
   output logic [NB_MASTER-1:0]                  m_err_o,
   output logic [NB_SLAVE-1:0]                   s_req_o,
   output logic [NB_SLAVE-1:0][ADDR_WIDTH-1:0]   s_addr_o,
   output logic [NB_SLAVE-1:0]                   s_we_o,
   output logic [NB_SLAVE-1:0][DATA_WIDTH/8-1:0] s_be_o,
   output logic [NB_SLAVE-1:0][DATA_WIDTH-1:0]   s_wdata_o,
   input  logic [NB_SLAVE-1:0]                   s_gnt_i,
   input  logic [NB_SLAVE-1:0]                   s_rvalid_i,
   input  logic [NB_SLAVE-1:0][DATA_WIDTH-1:0]   s_rdata_i
);

   localparam int MW = (NB_MASTER > 1) ? $clog2(NB_MASTER) : 1;
   localparam int SW = (NB_SLAVE > 1) ? $clog2(NB_SLAVE) : 1;
   localparam int BW = DATA_WIDTH / 8;
   localparam logic [DATA_WIDTH-1:0] ERR_DATA = DATA_WIDTH'(32'hBADACCE5);

   typedef struct packed {
      logic [ADDR_WIDTH-1:0] addr;
      logic                  we;
      logic [BW-1:0]         be;
      logic [DATA_WIDTH-1:0] wdata;
   } req_t;

   req_t [NB_MASTER-1:0]          m_pl;
   logic [NB_MASTER-1:0]          out_q, out_d;     // master OUTSTANDING
   logic [NB_MASTER-1:0]          err_q, err_d;     // error response due
   logic [NB_SLAVE-1:0]           busy_q, busy_d;
   logic [NB_SLAVE-1:0][MW-1:0]   owner_q, owner_d;
   logic [NB_SLAVE-1:0][MW-1:0]   rr_q, rr_d;
   logic [NB_SLAVE-1:0][MW-1:0]   win;
   logic [NB_MASTER-1:0]          hit, elig;
   logic [NB_MASTER-1:0][SW-1:0]  sel;
   logic [NB_SLAVE-1:0]           cand, hs, drop, tout;

   for (genvar m = 0; m < NB_MASTER; m++) begin : g_mst
      assign m_pl[m] = '{addr: m_addr_i[m], we: m_we_i[m],
                         be: m_be_i[m], wdata: m_wdata_i[m]};
   end

   // Address decode: scan downwards so the lowest matching region wins.
   always_comb begin
      hit = '0;
      sel = '0;
      for (int m = 0; m < NB_MASTER; m++) begin
         for (int k = NB_SLAVE - 1; k >= 0; k--) begin
            if (m_addr_i[m] >= start_addr_i[k] && m_addr_i[m] <= end_addr_i[k]) begin
               hit[m] = 1'b1;
               sel[m] = SW'(k);
            end
         end
      end
   end

   assign elig = m_req_i & ~out_q;

   // Round-robin search starting at rr_q[k].
   always_comb begin
      int idx;
      idx  = 0;
      cand = '0;
      win  = '0;
      for (int k = 0; k < NB_SLAVE; k++) begin
         for (int i = 0; i < NB_MASTER; i++) begin
            idx = (int'(rr_q[k]) + i) % NB_MASTER;
            if (!cand[k] && elig[idx] && hit[idx] && sel[idx] == SW'(k)) begin
               cand[k] = 1'b1;
               win[k]  = MW'(idx);
            end
         end
      end
   end

   // A BUSY slave may be re-issued in the cycle its response arrives.
   assign s_req_o = cand & (~busy_q | s_rvalid_i);
   assign hs      = s_req_o & s_gnt_i;

   for (genvar k = 0; k < NB_SLAVE; k++) begin : g_slv
      req_t pl;
      assign pl           = s_req_o[k] ? m_pl[win[k]] : req_t'('0);
      assign s_addr_o[k]  = pl.addr;
      assign s_we_o[k]    = pl.we;
      assign s_be_o[k]    = pl.be;
      assign s_wdata_o[k] = pl.wdata;
   end

   // Unmapped requests are accepted immediately by the error responder.
   assign err_d = elig & ~hit;

   always_comb begin
      m_gnt_o = err_d;
      for (int k = 0; k < NB_SLAVE; k++)
         if (hs[k]) m_gnt_o[win[k]] = 1'b1;
   end

   always_comb begin
      m_rvalid_o = err_q;
      m_err_o    = err_q;
      for (int m = 0; m < NB_MASTER; m++)
         m_rdata_o[m] = err_q[m] ? ERR_DATA : '0;
      for (int k = 0; k < NB_SLAVE; k++) begin
         if (busy_q[k] && s_rvalid_i[k] && !drop[k]) begin
            m_rvalid_o[owner_q[k]] = 1'b1;
            m_rdata_o[owner_q[k]]  = s_rdata_i[k];
         end
         if (tout[k]) begin
            m_rvalid_o[owner_q[k]] = 1'b1;
            m_err_o[owner_q[k]]    = 1'b1;
         end
      end
   end

   always_comb begin
      out_d   = (out_q & ~m_rvalid_o) | m_gnt_o;
      busy_d  = busy_q;
      owner_d = owner_q;
      rr_d    = rr_q;
      for (int k = 0; k < NB_SLAVE; k++) begin
         if (hs[k]) begin
            busy_d[k]  = 1'b1;
            owner_d[k] = win[k];
            rr_d[k]    = MW'((int'(win[k]) + 1) % NB_MASTER);
         end else if (s_rvalid_i[k]) begin
            busy_d[k]  = 1'b0;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_q   <= '0;
         err_q   <= '0;
         busy_q  <= '0;
         owner_q <= '0;
         rr_q    <= '0;
      end else begin
         out_q   <= out_d;
         err_q   <= err_d;
         busy_q  <= busy_d;
         owner_q <= owner_d;
         rr_q    <= rr_d;
      end
   end

`ifdef BUS_NODE_TIMEOUT_EN
   localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
   logic [NB_SLAVE-1:0][CW-1:0] cnt_q, cnt_d;
   logic [NB_SLAVE-1:0]         drop_q, drop_d, tout_q, tout_d;

   // Count starts at 1 in the first cycle after the grant. Reaching the
   // limit without a response raises a one-cycle error pulse to the owner.
   // The slave then stays BUSY in drop mode until its late response arrives.
   always_comb begin
      cnt_d  = cnt_q;
      drop_d = drop_q;
      tout_d = '0;
      for (int k = 0; k < NB_SLAVE; k++) begin
         if (hs[k]) begin
            cnt_d[k]  = CW'(1);
            drop_d[k] = 1'b0;
         end else if (busy_q[k] && s_rvalid_i[k]) begin
            cnt_d[k]  = '0;
            drop_d[k] = 1'b0;
         end else if (busy_q[k] && !drop_q[k]) begin
            if (cnt_q[k] == CW'(TIMEOUT_CYCLES)) begin
               drop_d[k] = 1'b1;
               tout_d[k] = 1'b1;
            end else begin
               cnt_d[k] = cnt_q[k] + CW'(1);
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q  <= '0;
         drop_q <= '0;
         tout_q <= '0;
      end else begin
         cnt_q  <= cnt_d;
         drop_q <= drop_d;
         tout_q <= tout_d;
      end
   end

   assign drop = drop_q;
   assign tout = tout_q;
`else
   logic unused_tmo;
   assign drop       = '0;
   assign tout       = '0;
   assign unused_tmo = (TIMEOUT_CYCLES != 0);
`endif

endmodule

// File: tb/tb_soc_bus_node.sv
module tb_soc_bus_node;
   localparam int NM = 3;
   localparam int NS = 3;
   localparam int AW = 32;
   localparam int DW = 32;
   localparam int BW = DW / 8;
   localparam logic [DW-1:0] ERRD = 32'hBADACCE5;

   logic                  clk = 1'b0;
   logic                  rst_n;
   logic [NS-1:0][AW-1:0] start_addr_i, end_addr_i;
   logic [NM-1:0]         m_req_i, m_we_i;
   logic [NM-1:0][AW-1:0] m_addr_i;
   logic [NM-1:0][BW-1:0] m_be_i;
   logic [NM-1:0][DW-1:0] m_wdata_i;
   logic [NM-1:0]         m_gnt_o, m_rvalid_o, m_err_o;
   logic [NM-1:0][DW-1:0] m_rdata_o;
   logic [NS-1:0]         s_req_o, s_we_o, s_gnt_i, s_rvalid_i;
   logic [NS-1:0][AW-1:0] s_addr_o;
   logic [NS-1:0][BW-1:0] s_be_o;
   logic [NS-1:0][DW-1:0] s_wdata_o, s_rdata_i;

   int checks   = 0;
   int failures = 0;

   soc_bus_node #(.NB_MASTER(NM), .NB_SLAVE(NS), .ADDR_WIDTH(AW),
                  .DATA_WIDTH(DW), .TIMEOUT_CYCLES(8)) dut (
      .clk(clk), .rst_n(rst_n),
      .start_addr_i(start_addr_i), .end_addr_i(end_addr_i),
      .m_req_i(m_req_i), .m_addr_i(m_addr_i), .m_we_i(m_we_i),
      .m_be_i(m_be_i), .m_wdata_i(m_wdata_i),
      .m_gnt_o(m_gnt_o), .m_rvalid_o(m_rvalid_o), .m_rdata_o(m_rdata_o),
      .m_err_o(m_err_o),
      .s_req_o(s_req_o), .s_addr_o(s_addr_o), .s_we_o(s_we_o),
      .s_be_o(s_be_o), .s_wdata_o(s_wdata_o),
      .s_gnt_i(s_gnt_i), .s_rvalid_i(s_rvalid_i), .s_rdata_i(s_rdata_i)
   );

   always #5 clk = ~clk;

   task automatic clr_inputs();
      m_req_i    = '0;
      m_addr_i   = '0;
      m_we_i     = '0;
      m_be_i     = '0;
      m_wdata_i  = '0;
      s_gnt_i    = '0;
      s_rvalid_i = '0;
      s_rdata_i  = '0;
   endtask

   // Region map used for the whole run (lowest index wins on overlap).
   function automatic int decode(input logic [AW-1:0] a);
      for (int k = 0; k < NS; k++)
         if (a >= start_addr_i[k] && a <= end_addr_i[k]) return k;
      return -1;
   endfunction

   function automatic logic [AW-1:0] pick_addr(input int s);
      case (s)
         0:       return 32'h1A10_0010;  // regions 0 and 2 overlap -> 0
         1:       return 32'h0010_0100;  // region 1
         2:       return 32'h1A80_0000;  // region 2 only
         3:       return 32'h3000_0000;  // unmapped
         default: return 32'h0000_0010;  // unmapped
      endcase
   endfunction

   task automatic test_reset();
      rst_n = 1'b0;
      clr_inputs();
      repeat (2) @(negedge clk);
      checks++;
      if ({m_gnt_o, m_rvalid_o, m_err_o, s_req_o, s_we_o} !== '0) begin
         failures++;
         $display("FAIL reset_ctrl: got %b want 0", {m_gnt_o, m_rvalid_o, m_err_o, s_req_o, s_we_o});
      end
      checks++;
      if ({m_rdata_o, s_addr_o, s_be_o, s_wdata_o} !== '0) begin
         failures++;
         $display("FAIL reset_data: outputs not all zero");
      end
      rst_n = 1'b1;
   endtask

   task automatic test_single_hit();
      @(negedge clk);
      m_req_i[0] = 1'b1; m_addr_i[0] = 32'h0010_0004; s_gnt_i[1] = 1'b1;
      #1;
      checks++;
      if (s_req_o !== 3'b010 || m_gnt_o !== 3'b001) begin
         failures++;
         $display("FAIL hit_req: s_req=%b gnt=%b want 010/001", s_req_o, m_gnt_o);
      end
      checks++;
      if (s_addr_o[1] !== 32'h0010_0004) begin
         failures++;
         $display("FAIL hit_addr: got %h want 00100004", s_addr_o[1]);
      end
      @(negedge clk);
      clr_inputs();
      s_rvalid_i[1] = 1'b1; s_rdata_i[1] = 32'h1234_5678;
      #1;
      checks++;
      if (m_rvalid_o !== 3'b001 || m_err_o !== 3'b000 || m_rdata_o[0] !== 32'h1234_5678) begin
         failures++;
         $display("FAIL hit_rsp: rv=%b err=%b data=%h want 001/000/12345678", m_rvalid_o, m_err_o, m_rdata_o[0]);
      end
      @(negedge clk);
      clr_inputs();
   endtask

   task automatic test_unmapped();
      @(negedge clk);
      m_req_i[2] = 1'b1; m_addr_i[2] = 32'h3000_0000; m_we_i[2] = 1'b1; s_gnt_i = '1;
      #1;
      checks++;
      if (m_gnt_o !== 3'b100 || s_req_o !== 3'b000 || m_rvalid_o !== 3'b000) begin
         failures++;
         $display("FAIL unmap_gnt: gnt=%b s_req=%b rv=%b want 100/000/000", m_gnt_o, s_req_o, m_rvalid_o);
      end
      @(negedge clk);
      clr_inputs();
      #1;
      checks++;
      if (m_rvalid_o !== 3'b100 || m_err_o !== 3'b100 || m_rdata_o[2] !== ERRD || s_req_o !== 3'b000) begin
         failures++;
         $display("FAIL unmap_rsp: rv=%b err=%b data=%h want 100/100/badacce5", m_rvalid_o, m_err_o, m_rdata_o[2]);
      end
      @(negedge clk);
      #1;
      checks++;
      if (m_rvalid_o !== 3'b000) begin
         failures++;
         $display("FAIL unmap_once: rv=%b want 000", m_rvalid_o);
      end
   endtask

   task automatic test_fairness();
      logic [NM-1:0] eg [6];
      logic [NM-1:0] er [6];
      eg = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b000};
      er = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b001, 3'b010};
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         clr_inputs();
         m_req_i    = (c < 5) ? 3'b111 : 3'b000;
         m_addr_i   = {3{32'h1A10_0000}};
         s_gnt_i[0] = 1'b1;
         s_rvalid_i[0] = (c > 0);
         s_rdata_i[0]  = 32'(c);
         #1;
         checks++;
         if (m_gnt_o !== eg[c] || m_rvalid_o !== er[c]) begin
            failures++;
            $display("FAIL fair_c%0d: gnt=%b rv=%b want %b/%b", c, m_gnt_o, m_rvalid_o, eg[c], er[c]);
         end
      end
      @(negedge clk);
      clr_inputs();
   endtask

   task automatic test_back_to_back();
      @(negedge clk);
      m_req_i[0] = 1'b1; m_addr_i[0] = 32'h1A10_0000; s_gnt_i[0] = 1'b1;
      #1;
      checks++;
      if (m_gnt_o !== 3'b001) begin
         failures++;
         $display("FAIL b2b_first: gnt=%b want 001", m_gnt_o);
      end
      @(negedge clk);
      clr_inputs();
      m_req_i[1] = 1'b1; m_addr_i[1] = 32'h1A10_0040; s_gnt_i[0] = 1'b1;
      #1;
      checks++;
      if (s_req_o !== 3'b000 || m_gnt_o !== 3'b000) begin
         failures++;
         $display("FAIL b2b_busy: s_req=%b gnt=%b want 000/000", s_req_o, m_gnt_o);
      end
      @(negedge clk);
      s_rvalid_i[0] = 1'b1; s_rdata_i[0] = 32'hCAFE_0000;
      #1;
      checks++;
      if (s_req_o !== 3'b001 || m_gnt_o !== 3'b010 || s_addr_o[0] !== 32'h1A10_0040) begin
         failures++;
         $display("FAIL b2b_issue: s_req=%b gnt=%b addr=%h want 001/010/1a100040", s_req_o, m_gnt_o, s_addr_o[0]);
      end
      checks++;
      if (m_rvalid_o !== 3'b001 || m_rdata_o[0] !== 32'hCAFE_0000) begin
         failures++;
         $display("FAIL b2b_oldrsp: rv=%b data=%h want 001/cafe0000", m_rvalid_o, m_rdata_o[0]);
      end
      @(negedge clk);
      clr_inputs();
      s_rvalid_i[0] = 1'b1; s_rdata_i[0] = 32'h0BAD_0001;
      #1;
      checks++;
      if (m_rvalid_o !== 3'b010 || m_rdata_o[1] !== 32'h0BAD_0001) begin
         failures++;
         $display("FAIL b2b_newrsp: rv=%b data=%h want 010/0bad0001", m_rvalid_o, m_rdata_o[1]);
      end
      @(negedge clk);
      clr_inputs();
   endtask

   task automatic test_overlap();
      @(negedge clk);
      m_req_i[1] = 1'b1; m_addr_i[1] = 32'h1A10_0000; s_gnt_i = '1;
      #1;
      checks++;
      if (s_req_o !== 3'b001 || m_gnt_o !== 3'b010) begin
         failures++;
         $display("FAIL overlap_lo: s_req=%b gnt=%b want 001/010", s_req_o, m_gnt_o);
      end
      @(negedge clk);
      clr_inputs();
      s_rvalid_i[0] = 1'b1;
      m_req_i[2] = 1'b1; m_addr_i[2] = 32'h1A80_0000; s_gnt_i = '1;
      #1;
      checks++;
      if (s_req_o !== 3'b100 || m_gnt_o !== 3'b100 || m_rvalid_o !== 3'b010) begin
         failures++;
         $display("FAIL overlap_hi: s_req=%b gnt=%b rv=%b want 100/100/010", s_req_o, m_gnt_o, m_rvalid_o);
      end
      @(negedge clk);
      clr_inputs();
      s_rvalid_i[2] = 1'b1;
      @(negedge clk);
      clr_inputs();
   endtask

   task automatic test_reset_mid();
      @(negedge clk);
      m_req_i[0] = 1'b1; m_addr_i[0] = 32'h0010_0000; s_gnt_i[1] = 1'b1;
      #1;
      checks++;
      if (m_gnt_o !== 3'b001) begin
         failures++;
         $display("FAIL rstmid_gnt: gnt=%b want 001", m_gnt_o);
      end
      @(negedge clk);
      clr_inputs();
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      s_rvalid_i[1] = 1'b1; s_rdata_i[1] = 32'h5555_AAAA;
      m_req_i[0] = 1'b1; m_addr_i[0] = 32'h1A80_0000; s_gnt_i[2] = 1'b1;
      #1;
      checks++;
      if (m_rvalid_o !== 3'b000 || m_gnt_o !== 3'b001 || s_req_o !== 3'b100) begin
         failures++;
         $display("FAIL rstmid_after: rv=%b gnt=%b s_req=%b want 000/001/100", m_rvalid_o, m_gnt_o, s_req_o);
      end
      @(negedge clk);
      clr_inputs();
      s_rvalid_i[2] = 1'b1;
      #1;
      checks++;
      if (m_rvalid_o !== 3'b001) begin
         failures++;
         $display("FAIL rstmid_rsp: rv=%b want 001", m_rvalid_o);
      end
      @(negedge clk);
      clr_inputs();
   endtask

`ifdef BUS_NODE_TIMEOUT_EN
   task automatic test_timeout();
      @(negedge clk);
      m_req_i[0] = 1'b1; m_addr_i[0] = 32'h0010_0000; s_gnt_i[1] = 1'b1;
      #1;
      checks++;
      if (m_gnt_o !== 3'b001) begin
         failures++;
         $display("FAIL tmo_gnt: gnt=%b want 001", m_gnt_o);
      end
      for (int c = 1; c <= 9; c++) begin
         @(negedge clk);
         clr_inputs();
         #1;
         checks++;
         if (m_rvalid_o !== ((c == 9) ? 3'b001 : 3'b000) || m_err_o !== ((c == 9) ? 3'b001 : 3'b000)) begin
            failures++;
            $display("FAIL tmo_c%0d: rv=%b err=%b", c, m_rvalid_o, m_err_o);
         end
      end
      @(negedge clk);
      s_rvalid_i[1] = 1'b1; s_rdata_i[1] = 32'hDEAD_0000;
      #1;
      checks++;
      if (m_rvalid_o !== 3'b000) begin
         failures++;
         $display("FAIL tmo_late: rv=%b want 000", m_rvalid_o);
      end
      @(negedge clk);
      clr_inputs();
      m_req_i[1] = 1'b1; m_addr_i[1] = 32'h0010_0000; s_gnt_i[1] = 1'b1;
      #1;
      checks++;
      if (s_req_o !== 3'b010 || m_gnt_o !== 3'b010) begin
         failures++;
         $display("FAIL tmo_reuse: s_req=%b gnt=%b want 010/010", s_req_o, m_gnt_o);
      end
      @(negedge clk);
      clr_inputs();
      s_rvalid_i[1] = 1'b1;
      #1;
      checks++;
      if (m_rvalid_o !== 3'b010 || m_err_o !== 3'b000) begin
         failures++;
         $display("FAIL tmo_rsp: rv=%b err=%b want 010/000", m_rvalid_o, m_err_o);
      end
      @(negedge clk);
      clr_inputs();
   endtask
`endif

   // Randomized traffic against a transaction-level model: each master is
   // idle or waiting, each slave has an owner or none, plus one rotating
   // pointer per slave and a pending-error flag per master.
   task automatic test_random(input int ncyc);
      int own [NS];
      int rr  [NS];
      int age [NS];
      int w   [NS];
      int dk  [NM];
      bit outm[NM], errp[NM], gl[NM], el[NM];
      logic [NM-1:0] eg, ev, ee;
      logic [NS-1:0] es;
      logic [NM-1:0][DW-1:0] ed;
      @(negedge clk);
      clr_inputs();
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      for (int k = 0; k < NS; k++) begin own[k] = -1; rr[k] = 0; age[k] = 0; end
      for (int m = 0; m < NM; m++) begin outm[m] = 0; errp[m] = 0; gl[m] = 0; end
      for (int c = 0; c < ncyc; c++) begin
         @(negedge clk);
         for (int m = 0; m < NM; m++) begin
            if (gl[m] || !m_req_i[m]) begin
               m_req_i[m]   = ($urandom_range(0, 9) < 6);
               m_addr_i[m]  = pick_addr(int'($urandom_range(0, 4)));
               m_we_i[m]    = 1'($urandom);
               m_be_i[m]    = BW'($urandom);
               m_wdata_i[m] = $urandom;
            end
         end
         for (int k = 0; k < NS; k++) begin
            if (own[k] >= 0) age[k]++;
            s_gnt_i[k]    = ($urandom_range(0, 2) != 0);
            s_rvalid_i[k] = (own[k] >= 0) && (($urandom_range(0, 1) == 1) || age[k] >= 5);
            s_rdata_i[k]  = $urandom;
         end
         #1;
         eg = '0; ev = '0; ee = '0; es = '0; ed = '0;
         for (int m = 0; m < NM; m++) begin
            dk[m] = decode(m_addr_i[m]);
            el[m] = m_req_i[m] && !outm[m];
            if (el[m] && dk[m] < 0) eg[m] = 1'b1;
            if (errp[m]) begin ev[m] = 1'b1; ee[m] = 1'b1; ed[m] = ERRD; end
         end
         for (int k = 0; k < NS; k++) begin
            w[k] = -1;
            if (own[k] < 0 || s_rvalid_i[k])
               for (int i = 0; i < NM; i++) begin
                  int idx;
                  idx = (rr[k] + i) % NM;
                  if (w[k] < 0 && el[idx] && dk[idx] == k) w[k] = idx;
               end
            if (w[k] >= 0) begin
               es[k] = 1'b1;
               if (s_gnt_i[k]) eg[w[k]] = 1'b1;
            end
            if (own[k] >= 0 && s_rvalid_i[k]) begin
               ev[own[k]] = 1'b1;
               ed[own[k]] = s_rdata_i[k];
            end
         end
         checks++;
         if (s_req_o !== es || m_gnt_o !== eg) begin
            failures++;
            $display("FAIL rnd_req c%0d: s_req=%b gnt=%b want %b/%b", c, s_req_o, m_gnt_o, es, eg);
         end
         checks++;
         if (m_rvalid_o !== ev || m_err_o !== (ee & ev)) begin
            failures++;
            $display("FAIL rnd_rsp c%0d: rv=%b err=%b want %b/%b", c, m_rvalid_o, m_err_o, ev, ee);
         end
         for (int m = 0; m < NM; m++) begin
            if (ev[m]) begin
               checks++;
               if (m_rdata_o[m] !== ed[m]) begin
                  failures++;
                  $display("FAIL rnd_rdata c%0d m%0d: got %h want %h", c, m, m_rdata_o[m], ed[m]);
               end
            end
         end
         for (int k = 0; k < NS; k++) begin
            if (es[k]) begin
               checks++;
               if (s_addr_o[k] !== m_addr_i[w[k]] || s_wdata_o[k] !== m_wdata_i[w[k]] ||
                   s_we_o[k] !== m_we_i[w[k]] || s_be_o[k] !== m_be_i[w[k]]) begin
                  failures++;
                  $display("FAIL rnd_payload c%0d s%0d: addr=%h want %h", c, k, s_addr_o[k], m_addr_i[w[k]]);
               end
            end
         end
         // Advance the model to the next cycle.
         for (int m = 0; m < NM; m++) begin
            outm[m] = (outm[m] && !ev[m]) || eg[m];
            errp[m] = el[m] && dk[m] < 0;
            gl[m]   = eg[m];
         end
         for (int k = 0; k < NS; k++) begin
            if (w[k] >= 0 && s_gnt_i[k]) begin
               own[k] = w[k];
               rr[k]  = (w[k] + 1) % NM;
               age[k] = 0;
            end else if (own[k] >= 0 && s_rvalid_i[k]) begin
               own[k] = -1;
            end
         end
      end
      @(negedge clk);
      clr_inputs();
   endtask

   initial begin
      start_addr_i[0] = 32'h1A10_0000; end_addr_i[0] = 32'h1A10_FFFF;
      start_addr_i[1] = 32'h0010_0000; end_addr_i[1] = 32'h001F_FFFF;
      start_addr_i[2] = 32'h1A00_0000; end_addr_i[2] = 32'h1AFF_FFFF;
      test_reset();
      test_single_hit();
      test_unmapped();
      test_fairness();
      test_back_to_back();
      test_overlap();
      test_reset_mid();
`ifdef BUS_NODE_TIMEOUT_EN
      test_timeout();
`endif
      test_random(400);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
